// File: rtl/turn_scheduler_if.sv
// Bundle of handshake and status signals between the turn scheduler and the
// rest of the game: aim FSM, link receiver, projectile engine and display.
interface turn_scheduler_if;
    logic       start;
    logic       first_player;
    logic       local_throw;
    logic       remote_throw;
    logic       flight_done;
    logic       hit;
    logic       whose_turn;
    logic       turn_owner;
    logic       launch;
    logic       launch_owner;
    logic [3:0] seconds_left;
    logic [1:0] hp_local;
    logic [1:0] hp_remote;
    logic       turn_timeout;
    logic       game_over;
    logic       winner;

    // Game-side view: drives requests and events, observes scheduler status.
    modport master (
        output start, first_player, local_throw, remote_throw, flight_done, hit,
        input  whose_turn, turn_owner, launch, launch_owner, seconds_left,
               hp_local, hp_remote, turn_timeout, game_over, winner
    );

    // Scheduler-side view.
    modport slave (
        input  start, first_player, local_throw, remote_throw, flight_done, hit,
        output whose_turn, turn_owner, launch, launch_owner, seconds_left,
               hp_local, hp_remote, turn_timeout, game_over, winner
    );
endinterface

// File: rtl/turn_scheduler.sv
// Turn scheduler: alternates turns between the local and remote player, owns
// the single projectile, runs the per-turn countdown and the swap lockout,
// tracks hit points and declares the winner. All outputs are registered.
module turn_scheduler #(
    parameter int CLK_HZ       = 65000000,
    parameter int TURN_SECONDS = 10,
    parameter int SWAP_CYCLES  = 32500000,
    parameter int MAX_HP       = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    turn_scheduler_if.slave bus
);

    localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SW_W = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLK_HZ - 1);
    localparam logic [SW_W-1:0] SW_LAST  = SW_W'(SWAP_CYCLES - 1);
    localparam logic [3:0]      SEC_INIT = 4'(TURN_SECONDS);
    localparam logic [1:0]      HP_INIT  = 2'(MAX_HP);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        LOCAL_AIM     = 3'd1,
        LOCAL_FLIGHT  = 3'd2,
        REMOTE_AIM    = 3'd3,
        REMOTE_FLIGHT = 3'd4,
        SWAP          = 3'd5,
        GAME_OVER     = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic [SW_W-1:0] swap_q, swap_d;
    logic [3:0]      seconds_left_q, seconds_left_d;
    logic [1:0]      hp_local_q, hp_local_d;
    logic [1:0]      hp_remote_q, hp_remote_d;
    logic            whose_turn_q, whose_turn_d;
    logic            turn_owner_q, turn_owner_d;
    logic            launch_q, launch_d;
    logic            launch_owner_q, launch_owner_d;
    logic            turn_timeout_q, turn_timeout_d;
    logic            game_over_q, game_over_d;
    logic            winner_q, winner_d;
    logic            throw_prev_q, throw_prev_d;

    // Only a fresh 0->1 transition of the aim FSM's throw enable is a throw.
    logic local_edge;
    assign local_edge = bus.local_throw & ~throw_prev_q;

    // Next-state and registered-output computation for the whole game FSM.
    always_comb begin
        logic aim_enter;
        logic aim_who;
        logic aim_count;

        state_d        = state_q;
        presc_d        = presc_q;
        swap_d         = swap_q;
        seconds_left_d = seconds_left_q;
        hp_local_d     = hp_local_q;
        hp_remote_d    = hp_remote_q;
        turn_owner_d   = turn_owner_q;
        game_over_d    = game_over_q;
        winner_d       = winner_q;
        launch_d       = 1'b0;
        launch_owner_d = 1'b0;
        turn_timeout_d = 1'b0;
        throw_prev_d   = bus.local_throw;
        aim_enter      = 1'b0;
        aim_who        = 1'b0;
        aim_count      = 1'b0;

        case (state_q)
            IDLE, GAME_OVER: begin
                if (bus.start) begin
                    hp_local_d  = HP_INIT;
                    hp_remote_d = HP_INIT;
                    game_over_d = 1'b0;
                    aim_enter   = 1'b1;
                    aim_who     = bus.first_player;
                end
            end
            LOCAL_AIM: begin
                if (local_edge) begin
                    launch_d       = 1'b1;
                    launch_owner_d = 1'b0;
                    state_d        = LOCAL_FLIGHT;
                end else begin
                    aim_count = 1'b1;
                end
            end
            REMOTE_AIM: begin
                if (bus.remote_throw) begin
                    launch_d       = 1'b1;
                    launch_owner_d = 1'b1;
                    state_d        = REMOTE_FLIGHT;
                end else begin
                    aim_count = 1'b1;
                end
            end
            LOCAL_FLIGHT: begin
                if (bus.flight_done) begin
                    swap_d  = '0;
                    state_d = SWAP;
                    if (bus.hit) begin
                        if (hp_remote_q <= 2'd1) begin
                            hp_remote_d = 2'd0;
                            game_over_d = 1'b1;
                            winner_d    = 1'b0;
                            state_d     = GAME_OVER;
                        end else begin
                            hp_remote_d = hp_remote_q - 2'd1;
                        end
                    end
                end
            end
            REMOTE_FLIGHT: begin
                if (bus.flight_done) begin
                    swap_d  = '0;
                    state_d = SWAP;
                    if (bus.hit) begin
                        if (hp_local_q <= 2'd1) begin
                            hp_local_d  = 2'd0;
                            game_over_d = 1'b1;
                            winner_d    = 1'b1;
                            state_d     = GAME_OVER;
                        end else begin
                            hp_local_d = hp_local_q - 2'd1;
                        end
                    end
                end
            end
            SWAP: begin
                if (swap_q == SW_LAST) begin
                    aim_enter = 1'b1;
                    aim_who   = ~turn_owner_q;
                end else begin
                    swap_d = swap_q + SW_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Countdown only runs while a player is aiming without having thrown;
        // reaching zero forfeits the turn.
        if (aim_count) begin
            if (presc_q == PS_LAST) begin
                presc_d = '0;
                if (seconds_left_q <= 4'd1) begin
                    seconds_left_d = 4'd0;
                    turn_timeout_d = 1'b1;
                    swap_d         = '0;
                    state_d        = SWAP;
                end else begin
                    seconds_left_d = seconds_left_q - 4'd1;
                end
            end else begin
                presc_d = presc_q + PS_W'(1);
            end
        end

        // Starting a turn reloads the countdown and records the owner.
        if (aim_enter) begin
            state_d        = aim_who ? REMOTE_AIM : LOCAL_AIM;
            seconds_left_d = SEC_INIT;
            presc_d        = '0;
            turn_owner_d   = aim_who;
        end

        whose_turn_d = (state_d != LOCAL_AIM);
    end

    // State and output registers; reset aborts any game in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            presc_q        <= '0;
            swap_q         <= '0;
            seconds_left_q <= 4'd0;
            hp_local_q     <= HP_INIT;
            hp_remote_q    <= HP_INIT;
            whose_turn_q   <= 1'b1;
            turn_owner_q   <= 1'b0;
            launch_q       <= 1'b0;
            launch_owner_q <= 1'b0;
            turn_timeout_q <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= 1'b0;
            throw_prev_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            swap_q         <= swap_d;
            seconds_left_q <= seconds_left_d;
            hp_local_q     <= hp_local_d;
            hp_remote_q    <= hp_remote_d;
            whose_turn_q   <= whose_turn_d;
            turn_owner_q   <= turn_owner_d;
            launch_q       <= launch_d;
            launch_owner_q <= launch_owner_d;
            turn_timeout_q <= turn_timeout_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
            throw_prev_q   <= throw_prev_d;
        end
    end

    assign bus.whose_turn   = whose_turn_q;
    assign bus.turn_owner   = turn_owner_q;
    assign bus.launch       = launch_q;
    assign bus.launch_owner = launch_owner_q;
    assign bus.seconds_left = seconds_left_q;
    assign bus.hp_local     = hp_local_q;
    assign bus.hp_remote    = hp_remote_q;
    assign bus.turn_timeout = turn_timeout_q;
    assign bus.game_over    = game_over_q;
    assign bus.winner       = winner_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed testbench for turn_scheduler with a shortened time base.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_turn_scheduler;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    turn_scheduler_if tif();

    turn_scheduler #(
        .CLK_HZ      (10),
        .TURN_SECONDS(3),
        .SWAP_CYCLES (4),
        .MAX_HP      (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (tif)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        tif.start        = 1'b0;
        tif.first_player = 1'b0;
        tif.local_throw  = 1'b0;
        tif.remote_throw = 1'b0;
        tif.flight_done  = 1'b0;
        tif.hit          = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start(input logic fp);
        tif.start        = 1'b1;
        tif.first_player = fp;
        tick();
        tif.start        = 1'b0;
    endtask

    // Reset values, first turn setup, and asynchronous abort mid-aim.
    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++; if (tif.whose_turn !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_whose_turn: got %b expected 1", tif.whose_turn); end
        vectors++; if (tif.turn_owner !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_turn_owner: got %b expected 0", tif.turn_owner); end
        vectors++; if (tif.launch !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_launch: got %b expected 0", tif.launch); end
        vectors++; if (tif.launch_owner !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_launch_owner: got %b expected 0", tif.launch_owner); end
        vectors++; if (tif.turn_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_timeout: got %b expected 0", tif.turn_timeout); end
        vectors++; if (tif.seconds_left !== 4'd0) begin miscompares++; $display("[TB] FAIL rst_seconds: got %0d expected 0", tif.seconds_left); end
        vectors++; if (tif.hp_local !== 2'd2) begin miscompares++; $display("[TB] FAIL rst_hp_local: got %0d expected 2", tif.hp_local); end
        vectors++; if (tif.hp_remote !== 2'd2) begin miscompares++; $display("[TB] FAIL rst_hp_remote: got %0d expected 2", tif.hp_remote); end
        vectors++; if (tif.game_over !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_game_over: got %b expected 0", tif.game_over); end
        vectors++; if (tif.winner !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_winner: got %b expected 0", tif.winner); end

        tif.local_throw = 1'b1;
        rst_n = 1'b1;
        tick();
        vectors++; if (tif.launch !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_launch: got %b expected 0", tif.launch); end
        tif.local_throw = 1'b0;
        tick();

        pulse_start(1'b0);
        vectors++; if (tif.whose_turn !== 1'b0) begin miscompares++; $display("[TB] FAIL start_whose_turn: got %b expected 0", tif.whose_turn); end
        vectors++; if (tif.seconds_left !== 4'd3) begin miscompares++; $display("[TB] FAIL start_seconds: got %0d expected 3", tif.seconds_left); end
        vectors++; if (tif.hp_local !== 2'd2 || tif.hp_remote !== 2'd2) begin miscompares++; $display("[TB] FAIL start_hp: got %0d/%0d expected 2/2", tif.hp_local, tif.hp_remote); end
        vectors++; if (tif.turn_owner !== 1'b0) begin miscompares++; $display("[TB] FAIL start_turn_owner: got %b expected 0", tif.turn_owner); end

        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        vectors++; if (tif.whose_turn !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_whose_turn: got %b expected 1", tif.whose_turn); end
        vectors++; if (tif.seconds_left !== 4'd0) begin miscompares++; $display("[TB] FAIL abort_seconds: got %0d expected 0", tif.seconds_left); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Local throw, local hit on remote, swap lockout length, remote turn.
    task automatic test_local_hit();
        apply_reset();
        pulse_start(1'b0);
        tif.local_throw = 1'b1;
        tick();
        vectors++; if (tif.launch !== 1'b1) begin miscompares++; $display("[TB] FAIL lh_launch: got %b expected 1", tif.launch); end
        vectors++; if (tif.launch_owner !== 1'b0) begin miscompares++; $display("[TB] FAIL lh_launch_owner: got %b expected 0", tif.launch_owner); end
        vectors++; if (tif.whose_turn !== 1'b1) begin miscompares++; $display("[TB] FAIL lh_whose_turn: got %b expected 1", tif.whose_turn); end
        tick();
        vectors++; if (tif.launch !== 1'b0) begin miscompares++; $display("[TB] FAIL lh_single_pulse: got %b expected 0", tif.launch); end
        tif.flight_done = 1'b1;
        tif.hit         = 1'b1;
        tick();
        tif.flight_done = 1'b0;
        tif.hit         = 1'b0;
        tif.local_throw = 1'b0;
        vectors++; if (tif.hp_remote !== 2'd1) begin miscompares++; $display("[TB] FAIL lh_hp_remote: got %0d expected 1", tif.hp_remote); end
        vectors++; if (tif.hp_local !== 2'd2) begin miscompares++; $display("[TB] FAIL lh_hp_local: got %0d expected 2", tif.hp_local); end
        repeat (3) tick();
        vectors++; if (tif.turn_owner !== 1'b0) begin miscompares++; $display("[TB] FAIL lh_swap_owner: got %b expected 0", tif.turn_owner); end
        tick();
        vectors++; if (tif.turn_owner !== 1'b1) begin miscompares++; $display("[TB] FAIL lh_remote_owner: got %b expected 1", tif.turn_owner); end
        vectors++; if (tif.whose_turn !== 1'b1) begin miscompares++; $display("[TB] FAIL lh_remote_whose: got %b expected 1", tif.whose_turn); end
        vectors++; if (tif.seconds_left !== 4'd3) begin miscompares++; $display("[TB] FAIL lh_remote_seconds: got %0d expected 3", tif.seconds_left); end
    endtask

    // Remote turn with no throw: countdown, single timeout, swap to local.
    task automatic test_remote_timeout();
        logic [3:0] exp_sec;
        apply_reset();
        pulse_start(1'b1);
        vectors++; if (tif.turn_owner !== 1'b1) begin miscompares++; $display("[TB] FAIL to_owner: got %b expected 1", tif.turn_owner); end
        for (int k = 1; k <= 33; k++) begin
            tick();
            exp_sec = (k < 10) ? 4'd3 : (k < 20) ? 4'd2 : (k < 30) ? 4'd1 : 4'd0;
            vectors++; if (tif.seconds_left !== exp_sec) begin miscompares++; $display("[TB] FAIL to_seconds[%0d]: got %0d expected %0d", k, tif.seconds_left, exp_sec); end
            vectors++; if (tif.turn_timeout !== (k == 30)) begin miscompares++; $display("[TB] FAIL to_pulse[%0d]: got %b expected %b", k, tif.turn_timeout, (k == 30)); end
            vectors++; if (tif.launch !== 1'b0) begin miscompares++; $display("[TB] FAIL to_launch[%0d]: got %b expected 0", k, tif.launch); end
            vectors++; if (tif.whose_turn !== 1'b1) begin miscompares++; $display("[TB] FAIL to_whose[%0d]: got %b expected 1", k, tif.whose_turn); end
        end
        tick();
        vectors++; if (tif.whose_turn !== 1'b0) begin miscompares++; $display("[TB] FAIL to_local_whose: got %b expected 0", tif.whose_turn); end
        vectors++; if (tif.turn_owner !== 1'b0) begin miscompares++; $display("[TB] FAIL to_local_owner: got %b expected 0", tif.turn_owner); end
        vectors++; if (tif.seconds_left !== 4'd3) begin miscompares++; $display("[TB] FAIL to_local_seconds: got %0d expected 3", tif.seconds_left); end
    endtask

    // Held throw level does not launch; remote_throw ignored; fresh edge launches.
    task automatic test_held_throw();
        apply_reset();
        tif.local_throw = 1'b1;
        tick();
        pulse_start(1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (tif.launch !== 1'b0) begin miscompares++; $display("[TB] FAIL ht_held[%0d]: got %b expected 0", k, tif.launch); end
        end
        tif.remote_throw = 1'b1;
        tick();
        tif.remote_throw = 1'b0;
        vectors++; if (tif.launch !== 1'b0) begin miscompares++; $display("[TB] FAIL ht_remote_ignored: got %b expected 0", tif.launch); end
        vectors++; if (tif.whose_turn !== 1'b0) begin miscompares++; $display("[TB] FAIL ht_still_aim: got %b expected 0", tif.whose_turn); end
        tif.local_throw = 1'b0;
        tick();
        vectors++; if (tif.launch !== 1'b0) begin miscompares++; $display("[TB] FAIL ht_drop: got %b expected 0", tif.launch); end
        tif.local_throw = 1'b1;
        tick();
        vectors++; if (tif.launch !== 1'b1) begin miscompares++; $display("[TB] FAIL ht_fresh_edge: got %b expected 1", tif.launch); end
        vectors++; if (tif.launch_owner !== 1'b0) begin miscompares++; $display("[TB] FAIL ht_owner: got %b expected 0", tif.launch_owner); end
        tif.local_throw = 1'b0;
    endtask

    // Throw edge coinciding with the final prescaler wrap: throw wins.
    task automatic test_throw_vs_timeout();
        apply_reset();
        pulse_start(1'b0);
        repeat (29) tick();
        vectors++; if (tif.seconds_left !== 4'd1) begin miscompares++; $display("[TB] FAIL tt_seconds: got %0d expected 1", tif.seconds_left); end
        tif.local_throw = 1'b1;
        tick();
        vectors++; if (tif.launch !== 1'b1) begin miscompares++; $display("[TB] FAIL tt_launch: got %b expected 1", tif.launch); end
        vectors++; if (tif.turn_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL tt_timeout: got %b expected 0", tif.turn_timeout); end
        tick();
        vectors++; if (tif.turn_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL tt_timeout_late: got %b expected 0", tif.turn_timeout); end
        vectors++; if (tif.whose_turn !== 1'b1) begin miscompares++; $display("[TB] FAIL tt_whose: got %b expected 1", tif.whose_turn); end
        tif.local_throw = 1'b0;
    endtask

    // Full game to a local win, then restart from GAME_OVER.
    task automatic test_game_over();
        apply_reset();
        pulse_start(1'b0);
        tif.local_throw = 1'b1;
        tick();
        tif.local_throw = 1'b0;
        tif.flight_done = 1'b1;
        tif.hit         = 1'b1;
        tick();
        tif.flight_done = 1'b0;
        tif.hit         = 1'b0;
        repeat (4) tick();
        tif.remote_throw = 1'b1;
        tick();
        tif.remote_throw = 1'b0;
        vectors++; if (tif.launch !== 1'b1 || tif.launch_owner !== 1'b1) begin miscompares++; $display("[TB] FAIL go_remote_launch: got %b/%b expected 1/1", tif.launch, tif.launch_owner); end
        tif.flight_done = 1'b1;
        tick();
        tif.flight_done = 1'b0;
        vectors++; if (tif.hp_local !== 2'd2) begin miscompares++; $display("[TB] FAIL go_miss_hp: got %0d expected 2", tif.hp_local); end
        repeat (4) tick();
        vectors++; if (tif.whose_turn !== 1'b0) begin miscompares++; $display("[TB] FAIL go_local_turn: got %b expected 0", tif.whose_turn); end
        tif.local_throw = 1'b1;
        tick();
        tif.local_throw = 1'b0;
        tif.flight_done = 1'b1;
        tif.hit         = 1'b1;
        tick();
        tif.flight_done = 1'b0;
        tif.hit         = 1'b0;
        vectors++; if (tif.hp_remote !== 2'd0) begin miscompares++; $display("[TB] FAIL go_hp_remote: got %0d expected 0", tif.hp_remote); end
        vectors++; if (tif.game_over !== 1'b1) begin miscompares++; $display("[TB] FAIL go_flag: got %b expected 1", tif.game_over); end
        vectors++; if (tif.winner !== 1'b0) begin miscompares++; $display("[TB] FAIL go_winner: got %b expected 0", tif.winner); end
        vectors++; if (tif.whose_turn !== 1'b1) begin miscompares++; $display("[TB] FAIL go_whose: got %b expected 1", tif.whose_turn); end
        tif.flight_done = 1'b1;
        tif.hit         = 1'b1;
        tick();
        tif.flight_done = 1'b0;
        tif.hit         = 1'b0;
        tick();
        vectors++; if (tif.hp_local !== 2'd2 || tif.hp_remote !== 2'd0) begin miscompares++; $display("[TB] FAIL go_hp_held: got %0d/%0d expected 2/0", tif.hp_local, tif.hp_remote); end
        vectors++; if (tif.game_over !== 1'b1) begin miscompares++; $display("[TB] FAIL go_flag_held: got %b expected 1", tif.game_over); end
        pulse_start(1'b0);
        vectors++; if (tif.game_over !== 1'b0) begin miscompares++; $display("[TB] FAIL rs_flag: got %b expected 0", tif.game_over); end
        vectors++; if (tif.hp_local !== 2'd2 || tif.hp_remote !== 2'd2) begin miscompares++; $display("[TB] FAIL rs_hp: got %0d/%0d expected 2/2", tif.hp_local, tif.hp_remote); end
        vectors++; if (tif.whose_turn !== 1'b0) begin miscompares++; $display("[TB] FAIL rs_whose: got %b expected 0", tif.whose_turn); end
        vectors++; if (tif.seconds_left !== 4'd3) begin miscompares++; $display("[TB] FAIL rs_seconds: got %0d expected 3", tif.seconds_left); end
    endtask

    // Scenario sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clear_inputs();
        tick();
        test_reset();
        test_local_hit();
        test_remote_timeout();
        test_held_throw();
        test_throw_vs_timeout();
        test_game_over();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
